uart_byte_tx: RTL and testbench

- UART 8N1 transmitter that sits downstream of the receive/latch stage.
- Consumes the byte presented on t0..t7 plus the tsent request from that stage and serialises it onto tx.
- Holds one pending byte, so a request arriving mid-frame is not lost.
- Reports busy, frame-done and overrun status to the display/control logic.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_byte_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_byte_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and framing constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int   DATA_BITS = 8;
    localparam int   STOP_BITS = 1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with clear and end-of-bit tick
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic clk_raw,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_raw) begin
        if (reset || clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 serialiser with a one-byte pending buffer
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic clk_raw,
    input  logic reset,
    input  logic t0,
    input  logic t1,
    input  logic t2,
    input  logic t3,
    input  logic t4,
    input  logic t5,
    input  logic t6,
    input  logic t7,
    input  logic tsent,
    output logic tx,
    output logic busy,
    output logic tdone,
    output logic overrun
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_e               state, state_next;
    logic [DATA_BITS-1:0] din;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] pend_data, pend_data_next;
    logic                 pend_full, pend_full_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic                 tsent_q;
    logic                 req;
    logic                 bit_end;
    logic                 baud_clear;
    logic                 frame_end;
    logic                 tx_next;
    logic                 busy_next;
    logic                 overrun_next;

    assign din = {t7, t6, t5, t4, t3, t2, t1, t0};
    assign req = tsent & ~tsent_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_raw(clk_raw),
        .reset  (reset),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk_raw) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            pend_data <= '0;
            pend_full <= 1'b0;
            bit_idx   <= '0;
            tsent_q   <= 1'b0;
            tx        <= LINE_IDLE;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            pend_data <= pend_data_next;
            pend_full <= pend_full_next;
            bit_idx   <= bit_idx_next;
            tsent_q   <= tsent;
            tx        <= tx_next;
            busy      <= busy_next;
            overrun   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift;
        pend_data_next = pend_data;
        pend_full_next = pend_full;
        bit_idx_next   = bit_idx;
        overrun_next   = 1'b0;
        frame_end      = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    shift_next = din;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_DATA) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == LAST_STOP) begin
                        frame_end = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // End of stop bit: the queued byte goes first, a coincident request refills the queue.
        if (frame_end) begin
            bit_idx_next = '0;
            if (pend_full) begin
                shift_next     = pend_data;
                state_next     = START;
                pend_full_next = req;
                if (req) begin
                    pend_data_next = din;
                end
            end else if (req) begin
                shift_next = din;
                state_next = START;
            end else begin
                state_next = IDLE;
            end
        end else if (req && state != IDLE) begin
            if (!pend_full) begin
                pend_data_next = din;
                pend_full_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end

        case (state_next)
            START:   tx_next = ~LINE_IDLE;
            DATA:    tx_next = shift_next[0];
            default: tx_next = LINE_IDLE;
        endcase

        busy_next  = (state_next != IDLE) | pend_full_next;
        baud_clear = (state == IDLE) || (state_next != state);
        tdone      = frame_end;
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - randomized self-checking bench against a frame-timeline model
module tb_uart_byte_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ts = 1'b0;
    logic [7:0] d = 8'h00;
    logic       tx, busy, tdone, overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic prev_ts = 1'b0;

    // Timeline model: each accepted byte becomes a frame with a start cycle, an end cycle
    // and the cycle it was captured (start of its busy contribution).
    int         f_start[$];
    int         f_end[$];
    int         f_cap[$];
    logic [7:0] f_byte[$];
    int         ovr[$];

    uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_raw(clk), .reset(rst),
        .t0(d[0]), .t1(d[1]), .t2(d[2]), .t3(d[3]),
        .t4(d[4]), .t5(d[5]), .t6(d[6]), .t7(d[7]),
        .tsent(ts), .tx(tx), .busy(busy), .tdone(tdone), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] expect_at(input int c);
        logic e_tx, e_busy, e_done, e_ovr;
        logic [7:0] fb;
        int k;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovr = 1'b0;
        for (int i = 0; i < f_start.size(); i++) begin
            if (f_cap[i] <= c && c < f_end[i]) e_busy = 1'b1;
            if (f_start[i] <= c && c < f_end[i]) begin
                k = (c - f_start[i]) / CPB;
                fb = f_byte[i];
                if (k == 0) e_tx = 1'b0;
                else if (k <= 8) e_tx = fb[k-1];
                else e_tx = 1'b1;
                if (c == f_start[i] + FRAME - 1) e_done = 1'b1;
            end
        end
        for (int j = 0; j < ovr.size(); j++)
            if (ovr[j] == c) e_ovr = 1'b1;
        return {e_tx, e_busy, e_done, e_ovr};
    endfunction

    task automatic model_req(input int t, input logic [7:0] b);
        int pend;
        int last;
        pend = 0;
        if (f_end.size() == 0 || f_end[f_end.size()-1] <= t) begin
            f_start.push_back(t); f_cap.push_back(t); f_end.push_back(t + FRAME); f_byte.push_back(b);
        end else begin
            for (int i = 0; i < f_start.size(); i++)
                if (f_start[i] > t) pend++;
            last = f_end[f_end.size()-1];
            if (pend == 0) begin
                f_start.push_back(last); f_cap.push_back(t); f_end.push_back(last + FRAME); f_byte.push_back(b);
            end else begin
                ovr.push_back(t);
            end
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic [7:0] b,
                         output logic [3:0] obs, output logic [3:0] exp);
        rst = r; ts = s; d = b;
        @(negedge clk);
        obs = {tx, busy, tdone, overrun};
        exp = expect_at(cyc);
        if (r) begin
            f_start.delete(); f_end.delete(); f_cap.delete(); f_byte.delete(); ovr.delete();
            prev_ts = 1'b0;
        end else begin
            if (s && !prev_ts) model_req(cyc + 1, b);
            prev_ts = s;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        logic [3:0] o, e;
        apply(1'b1, 1'b0, 8'h00, o, e);
        apply(1'b1, 1'b0, 8'h00, o, e);
    endtask

    task automatic test_reset();
        logic [3:0] o, e;
        apply(1'b1, 1'b0, 8'h00, o, e);
        apply(1'b1, 1'b0, 8'h00, o, e);
        for (int i = 0; i < 50; i++) begin
            apply(1'b0, 1'b0, 8'($urandom), o, e);
            vectors++;
            if (o !== e || o !== 4'b1000) begin
                miscompares++;
                $display("FAIL test_reset cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [3:0] o, e;
        int dones = 0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            apply(1'b0, i < 3, (i == 0) ? 8'h55 : 8'($urandom), o, e);
            dones += int'(o[1]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single_55 cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL single_55_tdone_count got %0d want 1", dones);
        end
    endtask

    task automatic test_held_request();
        logic [3:0] o, e;
        int dones = 0;
        do_reset();
        for (int i = 0; i < 130; i++) begin
            apply(1'b0, i < 100, (i == 0) ? 8'hA3 : 8'($urandom), o, e);
            dones += int'(o[1]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL held_A3 cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL held_A3_tdone_count got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] o, e;
        int dones = 0, busys = 0, ovrs = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            apply(1'b0, i == 0 || i == 13, (i == 0) ? 8'h0F : (i == 13) ? 8'hF0 : 8'($urandom), o, e);
            dones += int'(o[1]); busys += int'(o[2]); ovrs += int'(o[0]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
        vectors++;
        if (dones !== 2 || busys !== 80 || ovrs !== 0) begin
            miscompares++;
            $display("FAIL back_to_back_counts tdone/busy/overrun got %0d/%0d/%0d want 2/80/0", dones, busys, ovrs);
        end
    endtask

    task automatic test_overrun();
        logic [3:0] o, e;
        int dones = 0, ovrs = 0;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            apply(1'b0, i == 0 || i == 10 || i == 20,
                  (i == 0) ? 8'h01 : (i == 10) ? 8'h02 : (i == 20) ? 8'h03 : 8'($urandom), o, e);
            dones += int'(o[1]); ovrs += int'(o[0]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL overrun cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
        vectors++;
        if (dones !== 2 || ovrs !== 1) begin
            miscompares++;
            $display("FAIL overrun_counts tdone/overrun got %0d/%0d want 2/1", dones, ovrs);
        end
    endtask

    task automatic test_stop_boundary();
        logic [3:0] o, e;
        int dones = 0, busys = 0;
        logic hit;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            hit = (i == 0) || (i == 40) || (i == 45) || (i == 80);
            apply(1'b0, hit, 8'($urandom), o, e);
            dones += int'(o[1]); busys += int'(o[2]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stop_boundary cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
        vectors++;
        if (dones !== 4 || busys !== 160) begin
            miscompares++;
            $display("FAIL stop_boundary_counts tdone/busy got %0d/%0d want 4/160", dones, busys);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] o, e;
        int dones = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            apply(i == 21, i == 0 || i == 5 || i == 45, (i == 0) ? 8'hFF : 8'($urandom), o, e);
            dones += int'(o[1]);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL reset_mid_tdone_count got %0d want 1", dones);
        end
    endtask

    task automatic test_random();
        logic [3:0] o, e;
        logic s;
        s = 1'b0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            apply($urandom_range(0, 499) == 0, s, 8'($urandom), o, e);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random cyc=%0d {tx,busy,tdone,overrun} got %b want %b", cyc, o, e);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        cyc = 0;
        test_reset();
        test_single_byte();
        test_held_request();
        test_back_to_back();
        test_overrun();
        test_stop_boundary();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
